i2c_master_scheduler: RTL and testbench
=======================================

I2C_MASTER_SCHEDULER -- requirements
Module: i2c_master_scheduler

Interface
REQ-001 The block SHALL have parameters (name, default, meaning), one per line:
- NUM_REQ, 4, number of requesters.
- MAX_RETRY, 3, retries after arbitration loss.
- BACKOFF_CYCLES, 64, wait cycles before a retry.

REQ-002 The block SHALL have ports (name, direction, width, meaning), one per line:
- clk, in, 1, system clock.
- n_rst, in, 1, reset; one clock, synchronous, active-low.
- req, in, NUM_REQ, per-requester transaction request (level).
- req_addr, in, 10*NUM_REQ, packed bus addresses; requester i at [10i+9:10i].
- req_addr_mode, in, NUM_REQ, AddressMode per requester.
- req_dir, in, NUM_REQ, DataDirection per requester.
- req_len, in, 8*NUM_REQ, packed packet sizes.
- grant, out, NUM_REQ, one-hot owner of the master.
- done, out, 1, one-cycle completion pulse.
- done_status, out, 2, SchedStatus, valid when done=1.
- line_busy, in, 1, I2C bus busy.
- transaction_begin, out, 1, start request to the master.
- transaction_begin_clear, in, 1, master accepted the start.
- set_transaction_complete, in, 1, master finished OK.
- ack_error_set, in, 1, NACK detected.
- set_arbitration_lost, in, 1, master lost arbitration.
- bus_address, out, 10, latched address.
- address_mode, out, 1, latched AddressMode.
- data_direction, out, 1, latched DataDirection.
- packet_size, out, 8, latched length.

Function
REQ-003 States SHALL be IDLE, WAIT_LINE, START, ACTIVE, BACKOFF, DONE.
REQ-004 IDLE with any req=1 SHALL select a winner round-robin, beginning at the index after the last winner (index 0 after reset), and latch its addr/mode/dir/len.
- The transition to WAIT_LINE and the setting of grant happen in the same edge.
REQ-005 bus_address, address_mode, data_direction, packet_size and grant SHALL hold constant from winner latch until the cycle after DONE.
REQ-006 WAIT_LINE SHALL remain while line_busy=1; on line_busy=0 it SHALL go to START.
REQ-007 In START, transaction_begin SHALL be 1 and SHALL hold until transaction_begin_clear=1 is sampled; the next state is then ACTIVE with transaction_begin=0.
- transaction_begin is 0 in every other state.
REQ-008 In START or ACTIVE, events SHALL be handled in this priority:
- set_arbitration_lost first.
- ack_error_set second.
- set_transaction_complete last.
REQ-009 On arbitration lost with retry_cnt<MAX_RETRY, the block SHALL go to BACKOFF and increment retry_cnt.
- If retry_cnt=MAX_RETRY, it goes to DONE with status ARB_FAIL.
REQ-010 BACKOFF SHALL count exactly BACKOFF_CYCLES cycles, then go to WAIT_LINE.
REQ-011 ack_error_set SHALL go to DONE with status NACK; set_transaction_complete SHALL go to DONE with status OK.
REQ-012 DONE SHALL last one cycle and then return to IDLE.
- In that cycle: done=1, done_status valid, grant still set.
- On exit: last winner updated, retry_cnt cleared, grant cleared.
REQ-013 Deassertion of req after grant SHALL be ignored; the transaction runs to DONE.
REQ-014 A req still high after DONE SHALL be a new request competing in IDLE; there is no back-to-back grant without one IDLE cycle.
REQ-015 Master status inputs in IDLE, WAIT_LINE, BACKOFF and DONE SHALL be ignored.

Reset
REQ-016 With n_rst=0 at a clk edge, the block SHALL reset to:
- state IDLE, last winner NUM_REQ-1, retry_cnt 0, backoff counter 0.
- all outputs 0, including grant, done, done_status, transaction_begin and the latched configuration.
REQ-017 Reset mid-transaction SHALL abort with no done pulse.

Structure
REQ-018 The SchedState and SchedStatus enums (OK=0, NACK=1, ARB_FAIL=2) SHALL be added to i2c_pkg.
REQ-019 The round-robin selection SHALL be the sub-module rr_arbiter.
- Inputs: req, last winner. Output: one-hot winner.
- Purely combinational.

Verification
REQ-020 Single request: req=0001, addr=0x50, len=4, line_busy=0, begin_clear 2 cycles after begin, complete 20 cycles later -> grant=0001 through DONE; done=1 once with status OK; bus_address=0x50 and packet_size=4 throughout.
REQ-021 Fairness: req=1111 held for 8 transactions -> grant order 0001, 0010, 0100, 1000, 0001, ...
REQ-022 Line busy: line_busy=1 for 30 cycles after grant -> transaction_begin stays 0 for those 30 cycles and rises the cycle after line_busy=0.
REQ-023 Arbitration loss: set_arbitration_lost pulsed 4 times -> BACKOFF of 64 cycles entered three times, then done with ARB_FAIL, and transaction_begin asserted exactly 4 times.
REQ-024 Priority: ack_error_set and set_transaction_complete in the same cycle -> status NACK; adding set_arbitration_lost in that cycle -> BACKOFF.
REQ-025 Reset: n_rst=0 during ACTIVE -> next cycle all outputs 0, no done pulse, and the next arbitration starts at requester 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Shared types for the I2C master scheduler:
//   sched_state_t  - scheduler FSM states
//   sched_status_t - completion status reported with the done pulse
//   req_cfg_t      - per-requester transaction configuration (addr/mode/dir/len)
//   idx_width()    - index width helper that never returns 0
// ----------------------------------------------------------------------------
package i2c_pkg;

   localparam int ADDR_W = 10;
   localparam int LEN_W  = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_LINE = 3'd1,
      START     = 3'd2,
      ACTIVE    = 3'd3,
      BACKOFF   = 3'd4,
      DONE      = 3'd5
   } sched_state_t;

   typedef enum logic [1:0] {
      OK       = 2'd0,
      NACK     = 2'd1,
      ARB_FAIL = 2'd2
   } sched_status_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              mode;
      logic              dir;
      logic [LEN_W-1:0]  len;
   } req_cfg_t;

   localparam int CFG_W = $bits(req_cfg_t);

   // Width needed to hold values 0..n-1, clamped to at least one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/i2c_master_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector.
// Ports:
//   i_req      [NUM_REQ-1:0] - request vector
//   i_last_idx [IDX_W-1:0]   - index of the previous winner
//   o_winner   [NUM_REQ-1:0] - one-hot winner (all zero when no request)
// Search starts at the index just above i_last_idx and wraps around.
// ----------------------------------------------------------------------------
module rr_arbiter
   import i2c_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last_idx,
   output logic [NUM_REQ-1:0] o_winner
);

   logic [NUM_REQ-1:0] w_mask;
   logic [NUM_REQ-1:0] w_masked;
   logic [NUM_REQ-1:0] w_pick;

   // Mask keeps only requesters strictly above the previous winner.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign w_mask[gi] = (IDX_W'(gi) > i_last_idx);
   end

   assign w_masked = i_req & w_mask;
   // Nothing above the last winner: wrap and take the lowest requester overall.
   assign w_pick   = (|w_masked) ? w_masked : i_req;
   // Isolate the lowest set bit.
   assign o_winner = w_pick & (~w_pick + NUM_REQ'(1));

endmodule

// File: rtl/i2c_master_scheduler.sv
// ----------------------------------------------------------------------------
// i2c_master_scheduler
// Arbitrates NUM_REQ requesters onto a single I2C master, waits for a free
// line, issues the start handshake, handles arbitration loss with bounded
// retries and backoff, and reports completion with a one-cycle done pulse.
// Ports:
//   clk, n_rst                      - clock, synchronous active-low reset
//   req/req_addr/req_addr_mode/
//   req_dir/req_len                 - per-requester request and configuration
//   grant                           - one-hot owner of the master
//   done, done_status               - completion pulse and status
//   line_busy                       - bus busy from the master
//   transaction_begin               - start request to the master
//   transaction_begin_clear         - master accepted the start
//   set_transaction_complete,
//   ack_error_set,
//   set_arbitration_lost            - master status events
//   bus_address/address_mode/
//   data_direction/packet_size      - latched configuration of the winner
// ----------------------------------------------------------------------------
module i2c_master_scheduler
   import i2c_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int MAX_RETRY      = 3,
   parameter int BACKOFF_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [10*NUM_REQ-1:0]   req_addr,
   input  logic [NUM_REQ-1:0]      req_addr_mode,
   input  logic [NUM_REQ-1:0]      req_dir,
   input  logic [8*NUM_REQ-1:0]    req_len,
   output logic [NUM_REQ-1:0]      grant,
   output logic                    done,
   output logic [1:0]              done_status,
   input  logic                    line_busy,
   output logic                    transaction_begin,
   input  logic                    transaction_begin_clear,
   input  logic                    set_transaction_complete,
   input  logic                    ack_error_set,
   input  logic                    set_arbitration_lost,
   output logic [9:0]              bus_address,
   output logic                    address_mode,
   output logic                    data_direction,
   output logic [7:0]              packet_size
);

   localparam int IDX_W   = idx_width(NUM_REQ);
   localparam int RETRY_W = idx_width(MAX_RETRY + 1);
   localparam int BK_W    = idx_width(BACKOFF_CYCLES);

   sched_state_t        r_state;
   sched_status_t       r_status;
   logic [NUM_REQ-1:0]  r_grant;
   logic [IDX_W-1:0]    r_last_idx;
   logic [IDX_W-1:0]    r_grant_idx;
   logic [RETRY_W-1:0]  r_retry;
   logic [BK_W-1:0]     r_bk_cnt;
   logic                r_done;
   logic                r_begin;
   req_cfg_t            r_cfg;

   logic [NUM_REQ-1:0]              w_winner;
   logic [NUM_REQ:0][IDX_W-1:0]     w_idx_chain;
   logic [NUM_REQ:0][CFG_W-1:0]     w_cfg_chain;
   logic [IDX_W-1:0]                w_win_idx;
   req_cfg_t                        w_win_cfg;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .i_req      (req),
      .i_last_idx (r_last_idx),
      .o_winner   (w_winner)
   );

   // One-hot winner -> index and configuration through AND-OR chains.
   assign w_idx_chain[0] = '0;
   assign w_cfg_chain[0] = '0;
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
      req_cfg_t w_cfg_i;
      assign w_cfg_i = {req_addr[10*gi +: 10], req_addr_mode[gi], req_dir[gi], req_len[8*gi +: 8]};
      assign w_idx_chain[gi+1] = w_idx_chain[gi] | (w_winner[gi] ? IDX_W'(gi) : '0);
      assign w_cfg_chain[gi+1] = w_cfg_chain[gi] | (w_winner[gi] ? w_cfg_i : '0);
   end
   assign w_win_idx = w_idx_chain[NUM_REQ];
   assign w_win_cfg = w_cfg_chain[NUM_REQ];

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state     <= IDLE;
         r_status    <= OK;
         r_grant     <= '0;
         r_last_idx  <= IDX_W'(NUM_REQ - 1);   // first search starts at 0
         r_grant_idx <= '0;
         r_retry     <= '0;
         r_bk_cnt    <= '0;
         r_done      <= 1'b0;
         r_begin     <= 1'b0;
         r_cfg       <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_grant     <= w_winner;
                  r_grant_idx <= w_win_idx;
                  r_cfg       <= w_win_cfg;
                  r_state     <= WAIT_LINE;
               end
            end
            WAIT_LINE: begin
               if (!line_busy) begin
                  r_state <= START;
                  r_begin <= 1'b1;
               end
            end
            START, ACTIVE: begin
               // Arbitration loss outranks NACK, which outranks completion.
               if (set_arbitration_lost) begin
                  r_begin <= 1'b0;
                  if (r_retry < RETRY_W'(MAX_RETRY)) begin
                     r_retry  <= r_retry + RETRY_W'(1);
                     r_bk_cnt <= '0;
                     r_state  <= BACKOFF;
                  end else begin
                     r_status <= ARB_FAIL;
                     r_done   <= 1'b1;
                     r_state  <= DONE;
                  end
               end else if (ack_error_set) begin
                  r_begin  <= 1'b0;
                  r_status <= NACK;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end else if (set_transaction_complete) begin
                  r_begin  <= 1'b0;
                  r_status <= OK;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end else if (r_state == START && transaction_begin_clear) begin
                  r_begin <= 1'b0;
                  r_state <= ACTIVE;
               end
            end
            BACKOFF: begin
               if (r_bk_cnt == BK_W'(BACKOFF_CYCLES - 1)) begin
                  r_bk_cnt <= '0;
                  r_state  <= WAIT_LINE;
               end else begin
                  r_bk_cnt <= r_bk_cnt + BK_W'(1);
               end
            end
            DONE: begin
               // Configuration outputs keep their value until the next latch.
               r_grant    <= '0;
               r_last_idx <= r_grant_idx;
               r_retry    <= '0;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign grant             = r_grant;
   assign done              = r_done;
   assign done_status       = r_status;
   assign transaction_begin = r_begin;
   assign bus_address       = r_cfg.addr;
   assign address_mode      = r_cfg.mode;
   assign data_direction    = r_cfg.dir;
   assign packet_size       = r_cfg.len;

endmodule

// File: tb/tb_i2c_master_scheduler.sv
// ----------------------------------------------------------------------------
// tb_i2c_master_scheduler
// Directed stimulus with a queue-based scoreboard. Each test pushes the
// expected completion; a monitor process pops and compares on every done
// pulse and checks that the latched configuration matches while granted.
// ----------------------------------------------------------------------------
module tb_i2c_master_scheduler;

   localparam int NUM_REQ        = 4;
   localparam int MAX_RETRY      = 3;
   localparam int BACKOFF_CYCLES = 64;

   localparam logic [1:0] ST_OK   = 2'd0;
   localparam logic [1:0] ST_NACK = 2'd1;
   localparam logic [1:0] ST_ARB  = 2'd2;

   // Arbitration loss -> begin reappears after 64 backoff + 1 wait-line cycle,
   // counted from the first falling edge after the sampling edge.
   localparam int BK_GAP = 66;

   logic                  clk = 1'b0;
   logic                  n_rst;
   logic [NUM_REQ-1:0]    req;
   logic [10*NUM_REQ-1:0] req_addr;
   logic [NUM_REQ-1:0]    req_addr_mode;
   logic [NUM_REQ-1:0]    req_dir;
   logic [8*NUM_REQ-1:0]  req_len;
   logic [NUM_REQ-1:0]    grant;
   logic                  done;
   logic [1:0]            done_status;
   logic                  line_busy;
   logic                  transaction_begin;
   logic                  transaction_begin_clear;
   logic                  set_transaction_complete;
   logic                  ack_error_set;
   logic                  set_arbitration_lost;
   logic [9:0]            bus_address;
   logic                  address_mode;
   logic                  data_direction;
   logic [7:0]            packet_size;

   always #5 clk = ~clk;

   i2c_master_scheduler #(
      .NUM_REQ        (NUM_REQ),
      .MAX_RETRY      (MAX_RETRY),
      .BACKOFF_CYCLES (BACKOFF_CYCLES)
   ) dut (
      .clk                      (clk),
      .n_rst                    (n_rst),
      .req                      (req),
      .req_addr                 (req_addr),
      .req_addr_mode            (req_addr_mode),
      .req_dir                  (req_dir),
      .req_len                  (req_len),
      .grant                    (grant),
      .done                     (done),
      .done_status              (done_status),
      .line_busy                (line_busy),
      .transaction_begin        (transaction_begin),
      .transaction_begin_clear  (transaction_begin_clear),
      .set_transaction_complete (set_transaction_complete),
      .ack_error_set            (ack_error_set),
      .set_arbitration_lost     (set_arbitration_lost),
      .bus_address              (bus_address),
      .address_mode             (address_mode),
      .data_direction           (data_direction),
      .packet_size              (packet_size)
   );

   typedef struct {
      logic [3:0] grant;
      logic [9:0] addr;
      logic       mode;
      logic       dir;
      logic [7:0] len;
      logic [1:0] status;
   } exp_t;

   exp_t exp_q[$];

   logic [9:0] tb_addr [4] = '{10'h050, 10'h123, 10'h2A5, 10'h3FF};
   logic [7:0] tb_len  [4] = '{8'd4, 8'd8, 8'd16, 8'd255};
   logic [3:0] tb_onehot [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic       tb_mode [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic       tb_dir  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   int         fair_idx [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

   int n_pass = 0;
   int n_total = 0;
   int n_done = 0;
   int n_begin_rise = 0;
   int hold_bad = 0;
   int gap_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic push_exp(input int idx, input logic [1:0] st);
      exp_t e;
      e.grant  = tb_onehot[idx];
      e.addr   = tb_addr[idx];
      e.mode   = tb_mode[idx];
      e.dir    = tb_dir[idx];
      e.len    = tb_len[idx];
      e.status = st;
      exp_q.push_back(e);
   endtask

   // Monitor / scoreboard
   initial begin
      exp_t e;
      logic prev_done = 1'b0;
      logic prev_begin = 1'b0;
      forever begin
         @(negedge clk);
         if (transaction_begin && !prev_begin) n_begin_rise++;
         prev_begin = transaction_begin;
         if (prev_done && grant != 4'b0) gap_bad++;
         if (grant != 4'b0 && exp_q.size() > 0) begin
            e = exp_q[0];
            if ({grant, bus_address, address_mode, data_direction, packet_size} !==
                {e.grant, e.addr, e.mode, e.dir, e.len}) hold_bad++;
         end
         if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("done_status", done_status, e.status);
               check("done_grant", grant, e.grant);
               check("done_addr", bus_address, e.addr);
               check("done_len", packet_size, e.len);
               check("done_mode_dir", {address_mode, data_direction}, {e.mode, e.dir});
               $display("txn %0d: grant=%b addr=0x%0h len=%0d status=%0d",
                        n_done, grant, bus_address, packet_size, done_status);
            end
         end
         prev_done = done;
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_grant"}, grant, 0);
      check({tag, "_done"}, {done, done_status}, 0);
      check({tag, "_begin"}, transaction_begin, 0);
      check({tag, "_addr"}, bus_address, 0);
      check({tag, "_len"}, packet_size, 0);
      check({tag, "_mode_dir"}, {address_mode, data_direction}, 0);
   endtask

   task automatic wait_begin();
      bit seen = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (transaction_begin) begin seen = 1; break; end
      end
      check("begin_seen", seen, 1);
   endtask

   task automatic wait_grant();
      bit seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (grant != 4'b0) begin seen = 1; break; end
      end
      check("grant_seen", seen, 1);
   endtask

   task automatic wait_done();
      int start = n_done;
      bit seen = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         if (n_done != start) begin seen = 1; break; end
      end
      #1;
      check("done_seen", seen, 1);
   endtask

   task automatic clear_after(input int dly);
      repeat (dly) @(posedge clk);
      #1 transaction_begin_clear = 1'b1;
      @(posedge clk);
      #1 transaction_begin_clear = 1'b0;
   endtask

   task automatic pulse_event(input int dly, input logic arb, input logic nack, input logic ok);
      repeat (dly) @(posedge clk);
      #1;
      set_arbitration_lost     = arb;
      ack_error_set            = nack;
      set_transaction_complete = ok;
      @(posedge clk);
      #1;
      set_arbitration_lost     = 1'b0;
      ack_error_set            = 1'b0;
      set_transaction_complete = 1'b0;
   endtask

   task automatic measure_backoff();
      int cnt = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         cnt++;
         if (transaction_begin) break;
      end
      check("backoff_gap", cnt, BK_GAP);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 n_rst = 1'b0;
      @(posedge clk);
      #1 n_rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      n_rst                    = 1'b0;
      req                      = '0;
      line_busy                = 1'b0;
      transaction_begin_clear  = 1'b0;
      set_transaction_complete = 1'b0;
      ack_error_set            = 1'b0;
      set_arbitration_lost     = 1'b0;
      req_addr      = {tb_addr[3], tb_addr[2], tb_addr[1], tb_addr[0]};
      req_len       = {tb_len[3], tb_len[2], tb_len[1], tb_len[0]};
      req_addr_mode = {tb_mode[3], tb_mode[2], tb_mode[1], tb_mode[0]};
      req_dir       = {tb_dir[3], tb_dir[2], tb_dir[1], tb_dir[0]};

      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;
      @(negedge clk);
      check_zero("reset");

      // Single request, req dropped after grant
      @(posedge clk); #1;
      req = 4'b0001;
      push_exp(0, ST_OK);
      wait_grant();
      req = 4'b0000;
      wait_begin();
      clear_after(2);
      pulse_event(20, 1'b0, 1'b0, 1'b1);
      wait_done();

      // Fairness from a fresh reset
      do_reset();
      for (int k = 0; k < 8; k++) push_exp(fair_idx[k], ST_OK);
      req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         wait_begin();
         clear_after(1);
         pulse_event(3, 1'b0, 1'b0, 1'b1);
         wait_done();
      end
      req = 4'b0000;

      // Line busy for 30 cycles after grant; status inputs ignored meanwhile
      repeat (2) @(posedge clk); #1;
      line_busy = 1'b1;
      req = 4'b0010;
      push_exp(1, ST_OK);
      wait_grant();
      req = 4'b0000;
      ack_error_set = 1'b1;
      set_transaction_complete = 1'b1;
      base = 0;
      for (int i = 0; i < 29; i++) begin
         @(negedge clk);
         if (transaction_begin) base++;
      end
      check("busy_begin_low", base, 0);
      @(posedge clk); #1;
      line_busy = 1'b0;
      ack_error_set = 1'b0;
      set_transaction_complete = 1'b0;
      @(negedge clk);
      check("busy_release_begin0", transaction_begin, 0);
      @(negedge clk);
      check("busy_release_begin1", transaction_begin, 1);
      clear_after(2);
      pulse_event(5, 1'b0, 1'b0, 1'b1);
      wait_done();

      // Arbitration loss four times -> ARB_FAIL
      base = n_begin_rise;
      req = 4'b0100;
      push_exp(2, ST_ARB);
      for (int k = 0; k < 4; k++) begin
         if (k == 0) wait_begin();
         else measure_backoff();
         if (k == 0) req = 4'b0000;
         clear_after(2);
         pulse_event(3, 1'b1, 1'b0, 1'b0);
      end
      wait_done();
      check("arb_begin_count", n_begin_rise - base, 4);

      // Priority: NACK beats complete
      req = 4'b0001;
      push_exp(0, ST_NACK);
      wait_begin();
      req = 4'b0000;
      clear_after(2);
      pulse_event(3, 1'b0, 1'b1, 1'b1);
      wait_done();

      // Priority: arbitration loss beats both -> backoff, then OK
      req = 4'b0001;
      push_exp(0, ST_OK);
      wait_begin();
      req = 4'b0000;
      clear_after(2);
      pulse_event(3, 1'b1, 1'b1, 1'b1);
      measure_backoff();
      clear_after(2);
      pulse_event(3, 1'b0, 1'b0, 1'b1);
      wait_done();

      // Reset during ACTIVE aborts; next arbitration starts at requester 0
      base = n_done;
      req = 4'b1000;
      push_exp(3, ST_OK);
      wait_begin();
      clear_after(2);
      repeat (3) @(posedge clk);
      #1 n_rst = 1'b0;
      req = 4'b0000;
      @(posedge clk);
      #1 n_rst = 1'b1;
      void'(exp_q.pop_front());
      @(negedge clk);
      check_zero("abort");
      @(negedge clk);
      check("abort_no_done", n_done - base, 0);
      @(posedge clk); #1;
      req = 4'b1111;
      push_exp(0, ST_OK);
      wait_begin();
      req = 4'b0000;
      clear_after(2);
      pulse_event(3, 1'b0, 1'b0, 1'b1);
      wait_done();

      repeat (3) @(negedge clk);
      check("hold_config", hold_bad, 0);
      check("idle_gap", gap_bad, 0);
      check("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
